// File: rtl/rock_sequencer.sv
// rock_sequencer: sweeps a PWM duty word between endpoints once per frame, then parks it at rest
module rock_sequencer #(
  parameter int PERIOD = 24000,
  parameter int DUTY_MIN = 1200,
  parameter int DUTY_MAX = 2400,
  parameter int DUTY_REST = 1800,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stop,
  input  logic [7:0]   Step,
  input  logic [7:0]   Cycles,
  output logic [W-1:0] Duty,
  output logic         Busy,
  output logic         FrameTick,
  output logic         Done
);
  typedef enum logic [1:0] {IDLE, RISE, FALL, RET} state_t;
  localparam logic [W:0] MIN = (W+1)'(DUTY_MIN);
  localparam logic [W:0] MAX = (W+1)'(DUTY_MAX);
  localparam logic [W:0] REST = (W+1)'(DUTY_REST);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);
  state_t state;
  logic [W-1:0] cnt;
  logic [7:0] step_r, cyc_r, swings, swings_nx;
  logic stop_f, stop_now;
  logic [W:0] stp, duty_x, up, dn, ret;
  // one extra bit so Duty+Step never wraps in the endpoint comparisons
  always_comb begin
    stp = (W+1)'(step_r);
    duty_x = {1'b0, Duty};
    up = duty_x + stp;
    dn = duty_x - stp;
    ret = duty_x > REST ? (duty_x <= REST + stp ? REST : dn) : (up >= REST ? REST : up);
    swings_nx = swings == 8'hff ? swings : swings + 8'd1;
    stop_now = stop_f | Stop;
  end
  assign FrameTick = cnt == LAST;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      Duty <= REST[W-1:0];
      Busy <= 1'b0;
      Done <= 1'b0;
      step_r <= 8'd1;
      cyc_r <= '0;
      swings <= '0;
      stop_f <= 1'b0;
    end else begin
      cnt <= FrameTick ? '0 : cnt + W'(1);
      Done <= 1'b0;
      if (Busy && Stop) stop_f <= 1'b1;
      if (state == IDLE) begin
        if (Start) begin
          step_r <= Step == 8'd0 ? 8'd1 : Step;
          cyc_r <= Cycles;
          swings <= '0;
          stop_f <= 1'b0;
          state <= RISE;
          Busy <= 1'b1;
        end
      end else if (FrameTick) begin
        // a pending stop turns this very tick into the first return step
        if (stop_now || state == RET) begin
          Duty <= ret[W-1:0];
          if (ret == REST) begin
            state <= IDLE;
            Busy <= 1'b0;
            Done <= 1'b1;
            stop_f <= 1'b0;
          end else state <= RET;
        end else if (state == RISE) begin
          if (up >= MAX) begin
            Duty <= MAX[W-1:0];
            state <= FALL;
          end else Duty <= up[W-1:0];
        end else if (duty_x <= MIN + stp) begin
          Duty <= MIN[W-1:0];
          swings <= swings_nx;
          state <= (cyc_r != 8'd0 && swings_nx == cyc_r) ? RET : RISE;
        end else Duty <= dn[W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_rock_sequencer.sv
// tb_rock_sequencer: randomized scoreboard bench; a trajectory model predicts Duty/Busy/Done per frame
module tb_rock_sequencer;
  localparam int P = 10;
  localparam int DMIN = 10;
  localparam int DMAX = 20;
  localparam int DREST = 15;
  logic CLK = 0, Reset = 1, Start = 0, Stop = 0;
  logic [7:0] Step = 0, Cycles = 0;
  logic [15:0] Duty;
  logic Busy, FrameTick, Done;
  typedef struct {int duty; bit busy; bit done;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  bit prev_tick = 0;

  rock_sequencer #(.PERIOD(P), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_REST(DREST), .W(16)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Step(Step), .Cycles(Cycles),
    .Duty(Duty), .Busy(Busy), .FrameTick(FrameTick), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void push(int d, bit b, bit dn);
    exp_t e;
    e.duty = d; e.busy = b; e.done = dn;
    exp_q.push_back(e);
  endfunction

  // Expected duty after every frame tick; returns 1 if the stop request lands before a natural finish
  function automatic bit plan(int s, int c, int stop_at);
    int st = (s == 0) ? 1 : s;
    int d = DREST, sw = 0, t = 0;
    bit up = 1, stopped = 0;
    while (t < 1000) begin
      t++;
      if (stop_at > 0 && t > stop_at) begin stopped = 1; break; end
      if (up) begin
        if (d + st >= DMAX) begin d = DMAX; up = 0; end else d = d + st;
      end else begin
        if (d - st <= DMIN) begin d = DMIN; sw++; up = 1; end else d = d - st;
      end
      push(d, 1, 0);
      if (c != 0 && sw == c) break;
    end
    do begin
      if (d > DREST) d = (d - st <= DREST) ? DREST : d - st;
      else d = (d + st >= DREST) ? DREST : d + st;
      push(d, d != DREST, d == DREST);
    end while (d != DREST);
    push(DREST, 0, 0);
    return stopped;
  endfunction

  always @(negedge CLK) begin
    if (Reset) prev_tick = 0;
    else begin
      if (prev_tick && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("duty", int'(Duty), mon_e.duty);
        chk("busy", int'(Busy), int'(mon_e.busy));
        chk("done", int'(Done), int'(mon_e.done));
      end else if (prev_tick) begin
        chk("idle_duty", int'(Duty), DREST);
        chk("idle_busy", int'(Busy), 0);
        chk("idle_done", int'(Done), 0);
      end else chk("done_off_frame", int'(Done), 0);
      prev_tick = (FrameTick === 1'b1);
    end
  end

  task automatic wait_tick;
    int k = 0;
    do begin @(negedge CLK); k++; end while (FrameTick !== 1'b1 && k < 40);
    if (FrameTick !== 1'b1) chk("tick_timeout", 0, 1);
    @(posedge CLK); #1;
  endtask

  task automatic drain;
    int k = 0;
    while (exp_q.size() > 0 && k < 3000) begin @(posedge CLK); k++; end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  // Called just after the first negedge following a reset edge; the counter restarts at 0
  task automatic check_reset_state(string nm);
    int n = 1;
    chk({nm, "_duty"}, int'(Duty), DREST);
    chk({nm, "_busy"}, int'(Busy), 0);
    chk({nm, "_done"}, int'(Done), 0);
    while (FrameTick !== 1'b1 && n < 30) begin @(negedge CLK); n++; end
    chk({nm, "_first_tick"}, n, P);
  endtask

  task automatic run(int s, int c, int stop_at, bit varb, bit busy_start, bit both);
    bit used;
    int waited = 0;
    int k = 0;
    wait_tick;
    repeat (3) @(posedge CLK);
    #1;
    if (!both) begin Stop = 1; @(posedge CLK); #1; Stop = 0; end
    Step = 8'(s); Cycles = 8'(c); Start = 1; Stop = both;
    used = plan(s, c, stop_at);
    @(posedge CLK); #1;
    Start = 0; Stop = 0;
    chk("busy_after_start", int'(Busy), 1);
    chk("duty_held_after_start", int'(Duty), DREST);
    if (busy_start) begin
      wait_tick; waited = 1;
      Start = 1; Step = 8'($urandom); Cycles = 8'($urandom);
      @(posedge CLK); #1;
      Start = 0;
    end
    if (used) begin
      while (waited < stop_at) begin wait_tick; waited++; end
      if (varb) begin
        do begin @(negedge CLK); k++; end while (FrameTick !== 1'b1 && k < 40);
        Stop = 1;
      end else begin
        @(posedge CLK); #1;
        Stop = 1;
      end
      @(posedge CLK); #1;
      Stop = 0;
    end
    drain;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1 Reset = 0;
    @(negedge CLK);
    check_reset_state("reset");
    n = 0;
    do begin @(negedge CLK); n++; end while (FrameTick !== 1'b1 && n < 30);
    chk("tick_period", n, P);
    run(5, 1, 0, 0, 0, 0);
    run(0, 0, 3, 0, 0, 0);
    run(255, 2, 0, 0, 0, 0);
    run(5, 1, 0, 0, 1, 1);
    run(3, 0, 5, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      int s, c, sa;
      s = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 12));
      c = $urandom_range(0, 3);
      sa = (c == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 25)) : 0;
      run(s, c, sa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_tick;
    repeat (3) @(posedge CLK);
    #1;
    Step = 8'd5; Cycles = 8'd1; Start = 1;
    void'(plan(5, 1, 0));
    @(posedge CLK); #1;
    Start = 0;
    wait_tick;
    repeat (2) @(posedge CLK);
    #1;
    chk("pre_reset_duty", int'(Duty), DMAX);
    Reset = 1;
    exp_q.delete();
    @(posedge CLK); #1;
    Reset = 0;
    @(negedge CLK);
    check_reset_state("midrun_reset");
    repeat (25) @(negedge CLK);
    chk("post_reset_idle", int'(Duty), DREST);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
